inst_decoder: RTL and testbench
===============================

# inst_decoder

Registered RISC-V RV32I instruction decoder covering the opcode classes in `instructions_pkg`: R, I (ALU-immediate), S, B, LUI, AUIPC, JAL and custom-0. It accepts a 32-bit instruction word and PC over a valid/ready stream. It outputs the decoded class, register indices, function fields, a sign-extended 32-bit immediate and an illegal flag. A 2-entry skid buffer gives full throughput with a registered `in_ready`. It sits between instruction fetch and issue, and serves as the bench's reference decoder against the encoder-side typedefs.

## Interface
- `XLEN`, default 32: PC and immediate width. Only 32 is supported.
- `CNT_W`, default 32: width of the statistics counters.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input instruction valid.
- `in_ready` out 1: decoder can accept an input.
- `in_inst` in 32: raw instruction word (`instruction_t` layout).
- `in_pc` in XLEN: PC of `in_inst`.
- `flush` in 1: synchronous; discards all buffered entries.
- `out_valid` out 1: decoded output valid.
- `out_ready` in 1: consumer accepts the output.
- `out_pc` out XLEN: PC passed through.
- `out_class` out 3: instruction class. Encoding: 0 R, 1 I, 2 S, 3 B, 4 LUI, 5 AUIPC, 6 JAL, 7 CUSTOM0.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: raw fields inst[11:7], inst[19:15], inst[24:20].
- `out_funct3` out 3: inst[14:12].
- `out_funct7` out 7: inst[31:25].
- `out_imm` out XLEN: decoded immediate.
- `out_illegal` out 1: instruction not decodable.
- `decoded_cnt` out CNT_W: output handshakes completed.
- `illegal_cnt` out CNT_W: output handshakes completed with `out_illegal`=1.

## Operation
**Decode** (combinational on the input, captured into the buffer entry):
- Opcode is inst[6:0]. Any opcode outside the 8 listed classes sets illegal=1 and class=0. Register and function fields are still extracted; imm=0.

**Immediates:**
- R and CUSTOM0: imm = 0.
- I: imm = sext(inst[31:20]). Exception for funct3 001 and 101 (shifts): imm = {27'b0, inst[24:20]}.
- S: imm = sext({inst[31:25], inst[11:7]}).
- B: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- LUI and AUIPC: imm = {inst[31:12], 12'b0}.
- JAL: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).

**Illegal conditions** (in addition to unknown opcode):
- R: funct7 is neither 0000000 nor 0100000.
- R: funct7 = 0100000 with funct3 other than 000 or 101.
- I funct3 001: inst[31:25] ≠ 0.
- I funct3 101: inst[31:25] is neither 0000000 nor 0100000.
- S: funct3 > 010.
- B: funct3 is 010 or 011.
- CUSTOM0: funct3 ≠ 000.

**Buffering:**
- Two entries: output register O (drives all `out_*` signals) and skid register K.
- Accept occurs when `in_valid && in_ready`. `in_ready` = !K.valid, taken directly from a flop.
- Load rule: if O is empty or O is consumed this cycle, O loads from K when K is valid, otherwise from the accepted input. Any accepted input not loaded into O goes to K.
- Order is strictly preserved.

**Flush:**
- O and K are cleared next cycle.
- Flush overrides a same-cycle accept: the instruction is dropped.
- Flush overrides a same-cycle output handshake: counters still count that handshake.

**Counters:**
- Each counter increments by 1 per output handshake (`out_valid && out_ready`).
- Each wraps modulo 2^CNT_W. No saturation.

## Timing
- **Reset values:** `out_valid`=0, all `out_*` data=0, `decoded_cnt`=`illegal_cnt`=0, `in_ready`=1 (K empty).
- **Reset mid-operation:** both entries are discarded immediately (asynchronous).
- **Latency:** accept in cycle N gives `out_valid` in cycle N+1 when O is empty or draining.
- **Throughput:** one instruction per cycle while `out_ready`=1.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, all `out_*` signals are held stable.
- **Backpressure:** with `out_ready`=0, at most 2 instructions are held. `in_ready` falls the cycle after K fills and rises the cycle after K drains into O.
- **Full, simultaneous accept and consume:** with O and K both full, `in_ready`=0, so no accept is possible. On consume, O←K and K empties; `in_ready`=1 next cycle.
- **Counter update:** counters update on the clock edge ending the handshake cycle.

## Test plan
- **ADDI x1,x2,-1:** in_inst=0xFFF10093 → next cycle class=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, illegal=0.
- **SW x5,-8(x2):** 0xFE512C23 → class=2, rs1=2, rs2=5, funct3=2, imm=0xFFFFFFF8.
- **JAL x1,+2048 and LUI:** 0x001000EF → class=6, rd=1, imm=0x00000800. Then 0x123450B7 → class=4, rd=1, imm=0x12345000.
- **Illegal sequence:** 0x0000007F, then R-type with funct7=0000001 (0x02000033), then SLLI with inst[30]=1 (0x40009093), each consumed → illegal=1 each time; illegal_cnt=3, decoded_cnt=3.
- **Backpressure and order:** out_ready=0; offer 3 back-to-back instructions A, B, C → A and B accepted, in_ready=0 from the cycle after B. Raise out_ready → outputs A, B, C in order, no loss or duplication.
- **Flush and reset:** with O and K full, assert flush for 1 cycle with in_valid=1 → out_valid=0 next cycle, the offered instruction is dropped, in_ready=1. Separately, assert rst mid-stream → all outputs immediately return to their reset values.

Source files
------------

// File: rtl/inst_decoder.sv
// RV32I instruction decoder with a two-entry skid buffer.
// Decodes R/I/S/B/LUI/AUIPC/JAL/CUSTOM0 and counts handshakes.
module inst_decoder #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_class,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_C0  = 7'b0001011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic            ill;
  } dec_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_s, is_b;
  logic       is_lui, is_aui, is_jal, is_c0;
  dec_t       dec;

  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  assign is_r   = op == OP_R;
  assign is_i   = op == OP_I;
  assign is_s   = op == OP_S;
  assign is_b   = op == OP_B;
  assign is_lui = op == OP_LUI;
  assign is_aui = op == OP_AUI;
  assign is_jal = op == OP_JAL;
  assign is_c0  = op == OP_C0;

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_inst[11:7];
    dec.rs1 = in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.f3  = f3;
    dec.f7  = f7;
    unique case (1'b1)
      is_r: begin
        dec.cls = 3'd0;
        dec.ill = !((f7 == 7'd0) ||
                    ((f7 == F7_ALT) &&
                     ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      is_i: begin
        dec.cls = 3'd1;
        if (f3 == 3'b001) begin
          dec.imm = {27'b0, in_inst[24:20]};
          dec.ill = f7 != 7'd0;
        end else if (f3 == 3'b101) begin
          dec.imm = {27'b0, in_inst[24:20]};
          dec.ill = (f7 != 7'd0) && (f7 != F7_ALT);
        end else begin
          dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      is_s: begin
        dec.cls = 3'd2;
        dec.imm = {{20{in_inst[31]}}, f7, in_inst[11:7]};
        dec.ill = f3 > 3'b010;
      end
      is_b: begin
        dec.cls = 3'd3;
        dec.imm = {{20{in_inst[31]}}, in_inst[7],
                   in_inst[30:25], in_inst[11:8], 1'b0};
        dec.ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      is_lui: begin
        dec.cls = 3'd4;
        dec.imm = {in_inst[31:12], 12'b0};
      end
      is_aui: begin
        dec.cls = 3'd5;
        dec.imm = {in_inst[31:12], 12'b0};
      end
      is_jal: begin
        dec.cls = 3'd6;
        dec.imm = {{12{in_inst[31]}}, in_inst[19:12],
                   in_inst[20], in_inst[30:21], 1'b0};
      end
      is_c0: begin
        dec.cls = 3'd7;
        dec.ill = f3 != 3'b000;
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase
  end

  dec_t o_q, k_q;
  logic o_v, k_v;
  logic accept, consume, load_o;

  assign in_ready = !k_v;
  assign accept   = in_valid && in_ready;
  assign consume  = o_v && out_ready;
  assign load_o   = !o_v || out_ready;

  // O refills from K first so order is kept; K only fills while O stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
      k_q <= '0;
      o_v <= 1'b0;
      k_v <= 1'b0;
    end else if (flush) begin
      o_q <= '0;
      k_q <= '0;
      o_v <= 1'b0;
      k_v <= 1'b0;
    end else if (load_o) begin
      if (k_v) begin
        o_q <= k_q;
        o_v <= 1'b1;
        k_v <= 1'b0;
      end else if (accept) begin
        o_q <= dec;
        o_v <= 1'b1;
      end else begin
        o_v <= 1'b0;
      end
    end else if (accept) begin
      k_q <= dec;
      k_v <= 1'b1;
    end
  end

  // counting ignores flush: a handshake in a flush cycle still happened
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (consume) begin
      decoded_cnt <= decoded_cnt + CNT_W'(1);
      if (o_q.ill)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = o_v;
  assign out_pc      = o_q.pc;
  assign out_class   = o_q.cls;
  assign out_rd      = o_q.rd;
  assign out_rs1     = o_q.rs1;
  assign out_rs2     = o_q.rs2;
  assign out_funct3  = o_q.f3;
  assign out_funct7  = o_q.f7;
  assign out_imm     = o_q.imm;
  assign out_illegal = o_q.ill;

endmodule

// File: tb/tb_inst_decoder.sv
// Scoreboard bench for inst_decoder: random and directed stimulus
// against an arithmetic reference decoder.
module tb_inst_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_class;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [31:0] decoded_cnt;
  logic [31:0] illegal_cnt;

  inst_decoder #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_class(out_class),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned m_dec = 0;
  int unsigned m_ill = 0;
  exp_t        cur, prev, pe;
  logic        prev_hold = 1'b0;

  assign cur = {out_pc, out_class, out_rd, out_rs1, out_rs2,
                out_funct3, out_funct7, out_imm, out_illegal};

  task automatic chk(input string nm, input logic [95:0] got,
                     input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // reference: immediates built by weighted sums of instruction fields
  function automatic exp_t ref_decode(input logic [31:0] i,
                                      input logic [31:0] pc);
    exp_t e;
    int   imm;
    int   f3;
    int   f7;
    f3    = int'(i[14:12]);
    f7    = int'(i[31:25]);
    e     = '0;
    e.pc  = pc;
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.f3  = i[14:12];
    e.f7  = i[31:25];
    imm   = 0;
    case (int'(i[6:0]))
      'h33: begin
        e.cls = 0;
        e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      end
      'h13: begin
        e.cls = 1;
        if (f3 == 1) begin
          imm   = int'(i[24:20]);
          e.ill = f7 != 0;
        end else if (f3 == 5) begin
          imm   = int'(i[24:20]);
          e.ill = !(f7 == 0 || f7 == 32);
        end else begin
          imm = int'(i[31:20]);
          if (imm >= 2048) imm -= 4096;
        end
      end
      'h23: begin
        e.cls = 2;
        imm   = f7 * 32 + int'(i[11:7]);
        if (imm >= 2048) imm -= 4096;
        e.ill = f3 > 2;
      end
      'h63: begin
        e.cls = 3;
        imm   = int'(i[11:8]) * 2 + int'(i[30:25]) * 32
              + int'(i[7]) * 2048 - int'(i[31]) * 4096;
        e.ill = f3 == 2 || f3 == 3;
      end
      'h37: begin
        e.cls = 4;
        imm   = int'(i & 32'hFFFFF000);
      end
      'h17: begin
        e.cls = 5;
        imm   = int'(i & 32'hFFFFF000);
      end
      'h6F: begin
        e.cls = 6;
        imm   = int'(i[30:21]) * 2 + int'(i[20]) * 2048
              + int'(i[19:12]) * 4096 - int'(i[31]) * (1 << 20);
      end
      'h0B: begin
        e.cls = 7;
        e.ill = f3 != 0;
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = 32'(imm);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h23;
      3: r[6:0] = 7'h63;
      4: r[6:0] = 7'h37;
      5: r[6:0] = 7'h17;
      6: r[6:0] = 7'h6F;
      7: r[6:0] = 7'h0B;
      default: ;
    endcase
    k = $urandom_range(0, 3);
    if (k == 0) r[31:25] = 7'h00;
    if (k == 1) r[31:25] = 7'h20;
    if ($urandom_range(0, 1) == 0) r[14:12] = 3'($urandom_range(0, 2));
    return r;
  endfunction

  // stimulus side: every accepted instruction queues its expectation
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready && !flush)
      sb.push_back(ref_decode(in_inst, in_pc));
  end

  // monitor side: compare each handshake, hold stability, counters
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      m_dec     = 0;
      m_ill     = 0;
      sb.delete();
    end else begin
      if (prev_hold)
        chk("hold", cur, prev);
      if (out_valid && out_ready) begin
        chk("dec_cnt", decoded_cnt, m_dec);
        chk("ill_cnt", illegal_cnt, m_ill);
        m_dec++;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL underflow: got output pc %0h, expected none",
                   out_pc);
        end else begin
          pe = sb.pop_front();
          if (pe.ill) m_ill++;
          if (cur !== pe) begin
            n_fail++;
            $display("FAIL dec: got %0h expected %0h", cur, pe);
          end
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev      = cur;
      if (flush) sb.delete();
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL offer_timeout: got in_ready 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] cls,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [31:0] imm, input logic ill);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_class"}, out_class, cls);
    chk({nm, "_regs"}, {out_rd, out_rs1, out_rs2}, {rd, rs1, rs2});
    chk({nm, "_f3"}, out_funct3, f3);
    chk({nm, "_imm"}, out_imm, imm);
    chk({nm, "_ill"}, out_illegal, ill);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", {out_pc, out_imm, out_class}, 0);
    chk("rst_cnt", {decoded_cnt, illegal_cnt}, 0);

    out_ready = 1'b1;
    offer(32'hFFF10093, 32'h100);
    expect_out("addi", 3'd1, 5'd1, 5'd2, 5'd31, 3'd0, 32'hFFFFFFFF, 0);
    offer(32'hFE512C23, 32'h104);
    expect_out("sw", 3'd2, 5'd24, 5'd2, 5'd5, 3'd2, 32'hFFFFFFF8, 0);
    offer(32'h001000EF, 32'h108);
    expect_out("jal", 3'd6, 5'd1, 5'd0, 5'd1, 3'd0, 32'h00000800, 0);
    offer(32'h123450B7, 32'h10C);
    expect_out("lui", 3'd4, 5'd1, 5'd8, 5'd3, 3'd5, 32'h12345000, 0);

    do_reset();
    out_ready = 1'b1;
    offer(32'h0000007F, 32'h200);
    expect_out("ill_op", 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 1);
    offer(32'h02000033, 32'h204);
    expect_out("ill_r", 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 1);
    offer(32'h40009093, 32'h208);
    expect_out("ill_sll", 3'd1, 5'd1, 5'd1, 5'd0, 3'd1, 32'h0, 1);
    chk("ill_seq_cnt", {decoded_cnt, illegal_cnt}, {32'd3, 32'd3});

    out_ready = 1'b0;
    offer(32'h00100093, 32'hA00);
    offer(32'h00200113, 32'hB00);
    in_valid = 1'b1;
    in_inst  = 32'h00300193;
    in_pc    = 32'hC00;
    @(negedge clk);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_head_a", out_pc, 32'hA00);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_still", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_a", out_pc, 32'hA00);
    chk("bp_drain_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_rise", in_ready, 1);
    chk("bp_out_b", out_pc, 32'hB00);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_c", {out_valid, out_pc}, {1'b1, 32'hC00});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_empty", {31'd0, out_valid, 32'(sb.size())}, 0);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    offer(32'h00400213, 32'hD00);
    offer(32'h00500293, 32'hD04);
    in_valid = 1'b1;
    in_inst  = 32'h00600313;
    in_pc    = 32'hD08;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_sb_empty", sb.size(), 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fl_dropped", out_valid, 0);

    out_ready = 1'b0;
    offer(32'h00700393, 32'hE00);
    offer(32'hFFF00413, 32'hE04);
    rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_data", {out_pc, out_imm, out_class, out_rd}, 0);
    chk("ar_cnt", {decoded_cnt, illegal_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_inst   = rand_inst();
      in_pc     = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 63) == 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("end_sb_empty", sb.size(), 0);
    chk("end_dec_cnt", decoded_cnt, m_dec);
    chk("end_ill_cnt", illegal_cnt, m_ill);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
